// File: rtl/sprite_bounce_ctrl_pkg.sv
// Shared definitions for the bouncing-sprite motion sequencer: FSM states,
// coordinate width, default screen geometry and the per-axis reflect rule.
package sprite_bounce_ctrl_pkg;

    localparam int unsigned COORD_W      = 11;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_SPR_W    = 16;
    localparam int unsigned DEF_SPR_H    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC_X,
        ST_CALC_Y,
        ST_COMMIT
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               dir;
    } axis_t;

    // One axis step with clamping; the extra sum bit keeps the compare from wrapping.
    function automatic axis_t axis_step(input logic [COORD_W-1:0] pos,
                                        input logic               dir,
                                        input logic [COORD_W-1:0] step,
                                        input logic [COORD_W-1:0] lim);
        logic [COORD_W:0] sum;
        axis_t            r;
        sum   = {1'b0, pos} + {1'b0, step};
        r.pos = pos;
        r.dir = dir;
        if (dir) begin
            if (sum >= {1'b0, lim}) begin
                r.pos = lim;
                r.dir = 1'b0;
            end else begin
                r.pos = sum[COORD_W-1:0];
            end
        end else begin
            if (pos <= step) begin
                r.pos = '0;
                r.dir = 1'b1;
            end else begin
                r.pos = pos - step;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_bounce_ctrl_frame_tick_gen.sv
// Vsync leading-edge detector with a FRAMES_PER divider; emits a one-cycle
// tick in the edge cycle when the divider reaches its last count.
module frame_tick_gen #(
    parameter int unsigned FRAMES_PER = 1,
    parameter bit          VSYNC_POL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam logic [7:0] DIV_LAST = 8'(FRAMES_PER - 1);

    logic       vs_q;
    logic [7:0] div_q;
    logic [7:0] div_d;
    logic       lead_edge;

    assign lead_edge = (vsync_i == VSYNC_POL) && (vs_q != VSYNC_POL);

    always_comb begin
        div_d  = div_q;
        tick_o = 1'b0;
        if (enable_i && lead_edge) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_o = 1'b1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q  <= ~VSYNC_POL;
            div_q <= '0;
        end else begin
            vs_q  <= vsync_i;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/sprite_bounce_ctrl.sv
// Per-frame sprite motion sequencer: computes X then Y into shadow registers
// and commits both together after the vsync leading edge.
module sprite_bounce_ctrl
    import sprite_bounce_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned SPR_W      = DEF_SPR_W,
    parameter int unsigned SPR_H      = DEF_SPR_H,
    parameter int unsigned STEP       = 1,
    parameter int unsigned FRAMES_PER = 1,
    parameter int unsigned X_INIT     = 0,
    parameter int unsigned Y_INIT     = 0,
    parameter bit          VSYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               enable,
    output logic [COORD_W-1:0] spr_x,
    output logic [COORD_W-1:0] spr_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic               pos_update,
    output logic [1:0]         bounce,
    output logic               busy
);

    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(H_ACTIVE - SPR_W);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(V_ACTIVE - SPR_H);
    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] X_RST  = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(Y_INIT);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic [COORD_W-1:0] nx_q, nx_d, ny_q, ny_d;
    logic               ndx_q, ndx_d, ndy_q, ndy_d;
    logic               rfx_q, rfx_d, rfy_q, rfy_d;
    logic               pu_q, pu_d;
    logic [1:0]         bounce_q, bounce_d;
    logic               tick;
    axis_t              ax_w, ay_w;

    frame_tick_gen #(
        .FRAMES_PER (FRAMES_PER),
        .VSYNC_POL  (VSYNC_POL)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .vsync_i  (vsync),
        .enable_i (enable),
        .tick_o   (tick)
    );

    assign ax_w = axis_step(x_q, dx_q, STEP_C, X_MAX);
    assign ay_w = axis_step(y_q, dy_q, STEP_C, Y_MAX);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        ndx_d    = ndx_q;
        ndy_d    = ndy_q;
        rfx_d    = rfx_q;
        rfy_d    = rfy_q;
        pu_d     = 1'b0;
        bounce_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_CALC_X;
            end
            ST_CALC_X: begin
                nx_d    = ax_w.pos;
                ndx_d   = ax_w.dir;
                rfx_d   = (ax_w.dir != dx_q);
                state_d = ST_CALC_Y;
            end
            ST_CALC_Y: begin
                ny_d    = ay_w.pos;
                ndy_d   = ay_w.dir;
                rfy_d   = (ay_w.dir != dy_q);
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                x_d      = nx_q;
                y_d      = ny_q;
                dx_d     = ndx_q;
                dy_d     = ndy_q;
                pu_d     = 1'b1;
                bounce_d = {rfy_q, rfx_q};
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset also clears the shadows so an abandoned sequence leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= X_RST;
            y_q      <= Y_RST;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            nx_q     <= '0;
            ny_q     <= '0;
            ndx_q    <= 1'b1;
            ndy_q    <= 1'b1;
            rfx_q    <= 1'b0;
            rfy_q    <= 1'b0;
            pu_q     <= 1'b0;
            bounce_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            ndx_q    <= ndx_d;
            ndy_q    <= ndy_d;
            rfx_q    <= rfx_d;
            rfy_q    <= rfy_d;
            pu_q     <= pu_d;
            bounce_q <= bounce_d;
        end
    end

    assign spr_x      = x_q;
    assign spr_y      = y_q;
    assign dir_x      = dx_q;
    assign dir_y      = dy_q;
    assign pos_update = pu_q;
    assign bounce     = bounce_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sprite_bounce_ctrl.sv
// Bench for sprite_bounce_ctrl: three parameterisations share one stimulus
// stream and are checked against a frame-level motion model.
`timescale 1ns/1ps
module tb_sprite_bounce_ctrl;

    localparam int N = 3;
    localparam int P_XL   [N] = '{624, 18, 624};
    localparam int P_YL   [N] = '{464, 18, 464};
    localparam int P_STEP [N] = '{1, 4, 5};
    localparam int P_FP   [N] = '{1, 1, 3};
    localparam int P_XI   [N] = '{0, 2, 100};
    localparam int P_YI   [N] = '{0, 2, 460};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b1;
    logic        enable = 1'b1;
    logic [10:0] sx [N];
    logic [10:0] sy [N];
    logic        dx [N];
    logic        dy [N];
    logic        pu [N];
    logic [1:0]  bn [N];
    logic        busy [N];

    int errors = 0;
    int checks = 0;

    int       mx [N], my [N], mdx [N], mdy [N], mdiv [N];
    bit       mtick [N];
    logic [1:0] mbn [N];
    int       pu_cnt [N];
    logic [1:0] obs_bn [N];
    logic [5:1] obs_busy0, obs_pu0;
    logic [1:0] obs_bn0_late;

    always #5 clk = ~clk;

    sprite_bounce_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480), .SPR_W(16), .SPR_H(16), .STEP(1),
                         .FRAMES_PER(1), .X_INIT(0), .Y_INIT(0), .VSYNC_POL(1'b0)) u0 (
        .clk(clk), .rst(rst), .vsync(vsync), .enable(enable), .spr_x(sx[0]), .spr_y(sy[0]),
        .dir_x(dx[0]), .dir_y(dy[0]), .pos_update(pu[0]), .bounce(bn[0]), .busy(busy[0]));

    sprite_bounce_ctrl #(.H_ACTIVE(34), .V_ACTIVE(34), .SPR_W(16), .SPR_H(16), .STEP(4),
                         .FRAMES_PER(1), .X_INIT(2), .Y_INIT(2), .VSYNC_POL(1'b0)) u1 (
        .clk(clk), .rst(rst), .vsync(vsync), .enable(enable), .spr_x(sx[1]), .spr_y(sy[1]),
        .dir_x(dx[1]), .dir_y(dy[1]), .pos_update(pu[1]), .bounce(bn[1]), .busy(busy[1]));

    sprite_bounce_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480), .SPR_W(16), .SPR_H(16), .STEP(5),
                         .FRAMES_PER(3), .X_INIT(100), .Y_INIT(460), .VSYNC_POL(1'b0)) u2 (
        .clk(clk), .rst(rst), .vsync(vsync), .enable(enable), .spr_x(sx[2]), .spr_y(sy[2]),
        .dir_x(dx[2]), .dir_y(dy[2]), .pos_update(pu[2]), .bounce(bn[2]), .busy(busy[2]));

    // Moving toward an edge: stop on it and turn; never pass it.
    task automatic axis(input int pos, input int dir, input int step, input int lim,
                        output int npos, output int ndir);
        ndir = dir;
        if (dir == 1) begin
            npos = pos + step;
            if (npos >= lim) begin npos = lim; ndir = 0; end
        end else begin
            npos = pos - step;
            if (npos <= 0) begin npos = 0; ndir = 1; end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = P_XI[i]; my[i] = P_YI[i]; mdx[i] = 1; mdy[i] = 1; mdiv[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1; vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        model_reset();
    endtask

    // One vsync frame: edge, five observed cycles, random idle gap.
    task automatic frame(input bit drop_en);
        int nx, ndx, ny, ndy;
        @(posedge clk); #1; vsync = 1'b0;
        for (int i = 0; i < N; i++) begin
            mtick[i] = 1'b0; mbn[i] = 2'b00; pu_cnt[i] = 0; obs_bn[i] = 2'b00;
            if (enable) begin
                mdiv[i]++;
                if (mdiv[i] == P_FP[i]) begin mdiv[i] = 0; mtick[i] = 1'b1; end
            end
            if (mtick[i]) begin
                axis(mx[i], mdx[i], P_STEP[i], P_XL[i], nx, ndx);
                axis(my[i], mdy[i], P_STEP[i], P_YL[i], ny, ndy);
                mbn[i] = {ndy != mdy[i], ndx != mdx[i]};
                mx[i] = nx; mdx[i] = ndx; my[i] = ny; mdy[i] = ndy;
            end
        end
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1 && drop_en) enable = 1'b0;
            if (c == 2) vsync = 1'b1;
            obs_busy0[c] = busy[0];
            obs_pu0[c]   = pu[0];
            if (c == 5) obs_bn0_late = bn[0];
            for (int i = 0; i < N; i++) begin
                pu_cnt[i] += int'(pu[i]);
                if (c == 4) obs_bn[i] = bn[i];
            end
        end
        repeat ($urandom_range(3, 0)) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b1; enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (sx[i] !== 11'(P_XI[i]) || sy[i] !== 11'(P_YI[i]) || dx[i] !== 1'b1 || dy[i] !== 1'b1
                || busy[i] !== 1'b0 || pu[i] !== 1'b0 || bn[i] !== 2'b00) begin
                errors++;
                $display("FAIL reset[%0d]: got x=%0d y=%0d dir=%b%b busy=%b pu=%b bounce=%b, want x=%0d y=%0d dir=11 busy=0 pu=0 bounce=00",
                         i, sx[i], sy[i], dx[i], dy[i], busy[i], pu[i], bn[i], P_XI[i], P_YI[i]);
            end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_timing();
        frame(1'b0);
        checks++;
        if (obs_busy0 !== 5'b00111) begin
            errors++; $display("FAIL timing_busy: got %b want 00111 (E+5..E+1)", obs_busy0);
        end
        checks++;
        if (obs_pu0 !== 5'b01000) begin
            errors++; $display("FAIL timing_pos_update: got %b want 01000 (E+5..E+1)", obs_pu0);
        end
        checks++;
        if (sx[0] !== 11'd1 || sy[0] !== 11'd1) begin
            errors++; $display("FAIL timing_pos: got (%0d,%0d) want (1,1)", sx[0], sy[0]);
        end
        checks++;
        if (obs_bn[0] !== 2'b00 || obs_bn0_late !== 2'b00) begin
            errors++; $display("FAIL timing_bounce: got %b/%b want 00/00", obs_bn[0], obs_bn0_late);
        end
    endtask

    task automatic test_corner();
        int n = 0;
        do_reset();
        while (!(mx[1] == 2 && mdx[1] == 0 && my[1] == 2 && mdy[1] == 0) && n < 20) begin
            frame(1'b0);
            n++;
            checks++;
            if (sx[1] !== 11'(mx[1]) || dx[1] !== 1'(mdx[1])) begin
                errors++; $display("FAIL corner_walk: got x=%0d dx=%b want x=%0d dx=%0d", sx[1], dx[1], mx[1], mdx[1]);
            end
        end
        checks++;
        if (n >= 20) begin
            errors++; $display("FAIL corner_setup: got %0d frames, want start (2,2) dir 00 within 20", n);
        end
        frame(1'b0);
        checks++;
        if (sx[1] !== 11'd0 || sy[1] !== 11'd0 || dx[1] !== 1'b1 || dy[1] !== 1'b1 || obs_bn[1] !== 2'b11) begin
            errors++;
            $display("FAIL corner: got (%0d,%0d) dir=%b%b bounce=%b want (0,0) dir=11 bounce=11",
                     sx[1], sy[1], dx[1], dy[1], obs_bn[1]);
        end
    endtask

    task automatic test_x_bounce();
        int n = 0;
        do_reset();
        while (!(mx[0] == 623 && mdx[0] == 1) && n < 700) begin
            frame(1'b0);
            n++;
            checks++;
            if (sx[0] !== 11'(mx[0]) || sy[0] !== 11'(my[0]) || dx[0] !== 1'(mdx[0]) || dy[0] !== 1'(mdy[0])) begin
                errors++;
                $display("FAIL walk_u0: got (%0d,%0d) dir=%b%b want (%0d,%0d) dir=%0d%0d",
                         sx[0], sy[0], dx[0], dy[0], mx[0], my[0], mdx[0], mdy[0]);
            end
        end
        checks++;
        if (sx[0] !== 11'd623 || dx[0] !== 1'b1) begin
            errors++; $display("FAIL xb_setup: got x=%0d dx=%b want x=623 dx=1", sx[0], dx[0]);
        end
        frame(1'b0);
        checks++;
        if (sx[0] !== 11'd624 || dx[0] !== 1'b0 || obs_bn[0] !== 2'b01) begin
            errors++; $display("FAIL x_bounce: got x=%0d dx=%b bounce=%b want x=624 dx=0 bounce=01", sx[0], dx[0], obs_bn[0]);
        end
        frame(1'b0);
        checks++;
        if (sx[0] !== 11'd623 || dx[0] !== 1'b0 || obs_bn[0] !== 2'b00) begin
            errors++; $display("FAIL x_return: got x=%0d dx=%b bounce=%b want x=623 dx=0 bounce=00", sx[0], dx[0], obs_bn[0]);
        end
    endtask

    task automatic test_divider();
        int total = 0;
        logic [10:0] hold_x;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            frame(1'b0);
            total += pu_cnt[2];
        end
        checks++;
        if (total !== 2) begin
            errors++; $display("FAIL divider_pulses: got %0d want 2", total);
        end
        checks++;
        if (sx[2] !== 11'(mx[2]) || sy[2] !== 11'(my[2]) || dy[2] !== 1'(mdy[2])) begin
            errors++; $display("FAIL divider_pos: got (%0d,%0d) dy=%b want (%0d,%0d) dy=%0d", sx[2], sy[2], dy[2], mx[2], my[2], mdy[2]);
        end
        hold_x = sx[2];
        enable = 1'b0;
        total = 0;
        for (int k = 0; k < 5; k++) begin
            frame(1'b0);
            for (int i = 0; i < N; i++) total += pu_cnt[i];
        end
        checks++;
        if (total !== 0 || sx[2] !== hold_x) begin
            errors++; $display("FAIL freeze: got pulses=%0d x=%0d want pulses=0 x=%0d", total, sx[2], hold_x);
        end
        enable = 1'b1;
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        frame(1'b1);
        checks++;
        if (pu_cnt[0] !== 1 || sx[0] !== 11'(mx[0]) || sy[0] !== 11'(my[0])) begin
            errors++; $display("FAIL drop_completes: got pulses=%0d (%0d,%0d) want 1 (%0d,%0d)", pu_cnt[0], sx[0], sy[0], mx[0], my[0]);
        end
        frame(1'b0);
        checks++;
        if (pu_cnt[0] !== 0 || pu_cnt[1] !== 0) begin
            errors++; $display("FAIL drop_suppress: got pulses=%0d/%0d want 0/0", pu_cnt[0], pu_cnt[1]);
        end
        enable = 1'b1;
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        do_reset();
        enable = 1'b1;
        frame(1'b0);
        @(posedge clk); #1; vsync = 1'b0;
        @(posedge clk); #1; seen += int'(pu[0]);
        @(posedge clk); #1; seen += int'(pu[0]); rst = 1'b1;
        @(posedge clk); #1; seen += int'(pu[0]); rst = 1'b0; vsync = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1; seen += int'(pu[0]) + int'(pu[1]);
        end
        checks++;
        if (seen !== 0 || sx[0] !== 11'd0 || sy[0] !== 11'd0 || dx[0] !== 1'b1 || dy[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got pulses=%0d (%0d,%0d) dir=%b%b busy=%b want 0 (0,0) dir=11 busy=0",
                     seen, sx[0], sy[0], dx[0], dy[0], busy[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 80; k++) begin
            enable = ($urandom_range(3, 0) != 0);
            frame(1'b0);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (sx[i] !== 11'(mx[i]) || sy[i] !== 11'(my[i]) || dx[i] !== 1'(mdx[i]) || dy[i] !== 1'(mdy[i])
                    || pu_cnt[i] !== int'(mtick[i]) || obs_bn[i] !== mbn[i]) begin
                    errors++;
                    $display("FAIL random[%0d] frame %0d: got (%0d,%0d) dir=%b%b pulses=%0d bounce=%b want (%0d,%0d) dir=%0d%0d pulses=%0d bounce=%b",
                             i, k, sx[i], sy[i], dx[i], dy[i], pu_cnt[i], obs_bn[i],
                             mx[i], my[i], mdx[i], mdy[i], int'(mtick[i]), mbn[i]);
                end
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_corner();
        test_x_bounce();
        test_divider();
        test_enable_drop();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
